inst_decode_stage: RTL
======================

Name: inst_decode_stage

Overview:
- Registered IF/ID pipeline stage for the RV32I core.
- Accepts fetched {pc, inst} over a valid/ready handshake and pre-decodes the opcode into the 3-bit immediate-format select consumed by imm_gen.
- Extracts rd/rs1/rs2 and flags illegal encodings.
- Presents everything registered to the execute stage through a 2-entry skid buffer, so in_ready is a pure register output.

Parameters:
- PC_WIDTH, 32, width of the program counter carried with each instruction.

Ports:
- clk  input  1  single clock; all state on rising edge.
- resetn  input  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- flush  input  1  kill all buffered instructions (branch/jump redirect).
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  stage can accept; registered.
- in_pc  input  PC_WIDTH  PC of the presented instruction.
- in_inst  input  32  raw instruction word.
- out_valid  output  1  decoded instruction available.
- out_ready  input  1  execute accepts this cycle.
- out_pc  output  PC_WIDTH  PC of the head instruction.
- out_inst  output  32  raw word; drives imm_gen cpu_inst.
- out_imm_sel  output  3  drives imm_gen imm_sel.
- out_rd, out_rs1, out_rs2  output  5 each  inst[11:7], inst[19:15], inst[24:20].
- out_illegal  output  1  head instruction is not a supported encoding.

Behaviour:
- Reset (async, resetn=0):
  - out_valid=0, skid valid=0, in_ready=1.
  - All data outputs 0 (imm_sel=3'b000, illegal=0).
  - Assertion is permitted mid-transfer; every in-flight instruction is discarded.
- Handshakes:
  - Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
  - Latency 1 cycle: an instruction accepted at edge N appears on out_* after edge N when the main register is free.
- Pre-decode (combinational on in_inst, result registered with the instruction):
  - imm_sel encoding: 0 = I, 1 = S, 2 = B, 3 = J, 4 = U.
  - I (0): LOAD 0000011, OP-IMM 0010011, JALR 1100111, FENCE 0001111, SYSTEM 1110011.
  - S (1): STORE 0100011.
  - B (2): BRANCH 1100011.
  - J (3): JAL 1101111.
  - U (4): LUI 0110111, AUIPC 0010111.
  - OP 0110011: imm_sel=0, not illegal.
  - Any other opcode, or inst[1:0]!=2'b11: illegal=1, imm_sel=0. The instruction still flows; it is never dropped.
- Buffering (main register M, skid register S):
  - M empty, or M draining this cycle: input loads M. If S is valid, S moves into M and the input loads S. S is only ever filled while M is valid, so order is preserved.
  - M valid and not draining: the input (if accepted) loads S.
  - in_ready(next) = !S_valid(next). in_ready deasserts the cycle after S fills and reasserts the cycle after S empties.
  - Simultaneous accept and drain with S empty: M is replaced and occupancy is unchanged.
- Flush (synchronous, dominates everything):
  - Clears M and S valid at the edge. out_valid=0 the next cycle; in_ready=1 the next cycle.
  - An input presented in the flush cycle is dropped even if in_ready=1.
  - An output transfer in the flush cycle still counts for execute; flush is applied after it.
- out_* data is stable while out_valid && !out_ready. Data with out_valid=0 is don't-care, but is held at its last value (no toggling).

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants (OPC_LOAD, OPC_OP_IMM, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_OP, OPC_FENCE, OPC_SYSTEM);
  - IMM_SEL_I/S/B/J/U codes, shared with imm_gen.
- Sub-module inst_predecode (combinational: inst → imm_sel, illegal, register fields), instantiated once on the input path. The stage itself holds only the M/S registers and the valid/ready control.

Test Plan:
- Reset, then in_inst=0x00500093 (addi x1,x0,5), pc=0x100, out_ready=1 → one cycle later: out_valid=1, imm_sel=0, rd=1, rs1=0, illegal=0, out_pc=0x100.
- Opcode sweep, back-to-back with out_ready=1:
  - 0x00112423 (sw) → imm_sel=1.
  - 0x00208463 (beq) → imm_sel=2.
  - 0x008000EF (jal) → imm_sel=3.
  - 0x123450B7 (lui) → imm_sel=4.
  - 0x002081B3 (add) → imm_sel=0, illegal=0.
  - Expect one output per cycle with no bubbles.
- Backpressure: out_ready=0, three in_valid instructions A, B, C → A in M, B in S, in_ready low the cycle after B, C held by fetch. Raise out_ready → A, B, C emerge in order, no loss, no duplication.
- Flush with M and S full, plus in_valid=1 on the flush edge → out_valid=0 next cycle, in_ready=1, the presented instruction never appears at the output.
- Illegal encodings: 0x00000000 and 0xFFFFFFFF → out_illegal=1, imm_sel=0, still delivered in order.
- resetn pulsed low asynchronously mid-cycle while M/S are full → out_valid drops immediately without waiting for clk, in_ready=1; normal operation resumes on the first edge after release.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I opcode and immediate-format constants shared by decode and imm_gen
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] IMM_SEL_I = 3'd0;
    localparam logic [2:0] IMM_SEL_S = 3'd1;
    localparam logic [2:0] IMM_SEL_B = 3'd2;
    localparam logic [2:0] IMM_SEL_J = 3'd3;
    localparam logic [2:0] IMM_SEL_U = 3'd4;

    typedef struct packed {
        logic [2:0] imm_sel;
        logic       illegal;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } predecode_t;

endpackage

// File: rtl/inst_predecode.sv
// rtl/inst_predecode.sv - combinational opcode pre-decode: immediate format, legality, register fields
module inst_predecode
    import riscv_pkg::*;
(
    input  logic [31:0] inst,
    output predecode_t  dec
);

    always_comb begin
        dec         = '0;
        dec.rd      = inst[11:7];
        dec.rs1     = inst[19:15];
        dec.rs2     = inst[24:20];
        dec.imm_sel = IMM_SEL_I;
        dec.illegal = 1'b0;
        // every listed opcode ends in 2'b11, so compressed/invalid low bits fall to default
        case (inst[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR,
            OPC_FENCE, OPC_SYSTEM, OPC_OP: dec.imm_sel = IMM_SEL_I;
            OPC_STORE:                     dec.imm_sel = IMM_SEL_S;
            OPC_BRANCH:                    dec.imm_sel = IMM_SEL_B;
            OPC_JAL:                       dec.imm_sel = IMM_SEL_J;
            OPC_LUI, OPC_AUIPC:            dec.imm_sel = IMM_SEL_U;
            default:                       dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/inst_decode_stage.sv
// rtl/inst_decode_stage.sv - registered IF/ID stage with 2-entry skid buffer and opcode pre-decode
module inst_decode_stage
    import riscv_pkg::*;
#(
    parameter int PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PC_WIDTH-1:0] in_pc,
    input  logic [31:0]         in_inst,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic [31:0]         out_inst,
    output logic [2:0]          out_imm_sel,
    output logic [4:0]          out_rd,
    output logic [4:0]          out_rs1,
    output logic [4:0]          out_rs2,
    output logic                out_illegal
);

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [31:0]         inst;
        predecode_t          dec;
    } entry_t;

    predecode_t in_dec;
    entry_t     in_entry;
    entry_t     m_data;
    entry_t     s_data;
    logic       m_valid;
    logic       s_valid;
    logic       in_fire;
    logic       m_free;

    inst_predecode u_predecode (
        .inst (in_inst),
        .dec  (in_dec)
    );

    assign in_entry = '{pc: in_pc, inst: in_inst, dec: in_dec};
    assign in_fire  = in_valid && in_ready && !flush;
    assign m_free   = !m_valid || out_ready;

    // data registers load only on a real transfer so outputs never toggle while idle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_valid  <= 1'b0;
            s_valid  <= 1'b0;
            in_ready <= 1'b1;
            m_data   <= '0;
            s_data   <= '0;
        end else if (flush) begin
            m_valid  <= 1'b0;
            s_valid  <= 1'b0;
            in_ready <= 1'b1;
        end else if (m_free) begin
            if (s_valid) begin
                m_data  <= s_data;
                m_valid <= 1'b1;
                s_valid <= in_fire;
                in_ready <= !in_fire;
                if (in_fire) begin
                    s_data <= in_entry;
                end
            end else begin
                m_valid  <= in_fire;
                in_ready <= 1'b1;
                if (in_fire) begin
                    m_data <= in_entry;
                end
            end
        end else begin
            if (in_fire) begin
                s_data   <= in_entry;
                s_valid  <= 1'b1;
                in_ready <= 1'b0;
            end
        end
    end

    assign out_valid   = m_valid;
    assign out_pc      = m_data.pc;
    assign out_inst    = m_data.inst;
    assign out_imm_sel = m_data.dec.imm_sel;
    assign out_rd      = m_data.dec.rd;
    assign out_rs1     = m_data.dec.rs1;
    assign out_rs2     = m_data.dec.rs2;
    assign out_illegal = m_data.dec.illegal;

endmodule
